// File: rtl/hwag_pkg.sv
// hwag_pkg: shared constants for the hwag angle-generator front end.
// Holds the bus widths, the register map addresses and the control and
// status bit positions used by hwag and hwag_vr_filter.
// Optional feature macro used by the top level: HWAG_PERIOD_EN.
package hwag_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 8;
  localparam int REG_NUM   = 64;
  localparam int REG_IDX_W = 6;   // log2(REG_NUM)

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t FILTER_ADDR    = 8'd0;
  localparam addr_t HWACR0_ADDR    = 8'd64;
  localparam addr_t HWASR0_ADDR    = 8'd65;
  localparam addr_t PERIOD_LO_ADDR = 8'd66;
  localparam addr_t PERIOD_HI_ADDR = 8'd67;

  localparam int HWACR0_EN_BIT = 0;
  localparam int HWASR0_VR_BIT = 0;
  localparam int HWASR0_PV_BIT = 1;

endpackage

// File: rtl/hwag_vr_filter.sv
// hwag_vr_filter: synchronizes the raw VR comparator signal and rejects
// pulses shorter than filter+1 clocks.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - filter enable; when low the output is forced to 0
//   filter    - mismatch count threshold
//   vr_in     - raw VR input, asynchronous to clk
//   vr_out    - filtered VR output
module hwag_vr_filter
  import hwag_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] filter,
  input  logic              vr_in,
  output logic              vr_out
);

  logic              sync1_q, sync2_q;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              out_q, out_d;

  // cnt_q counts consecutive cycles where the synchronized input differs
  // from the output; the output flips on the (filter+1)-th such cycle.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (!en) begin
      out_d = 1'b0;
    end else if (sync2_q != out_q) begin
      if (cnt_q == filter) begin
        out_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // The synchronizer runs regardless of en so enabling starts from a
  // settled value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      sync1_q <= vr_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign vr_out = out_q;

endmodule

// File: rtl/hwag.sv
// hwag: hardware angle generator front end. Register bank on an
// SRAM-style bus, VR glitch filter and optional tooth-period capture.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   ssram_we    - write strobe (sampled on clk)
//   ssram_re    - read enable (combinational read)
//   ssram_addr  - register address
//   ssram_data  - bidirectional data, driven only while reading
//   vr_in       - raw VR comparator output
//   vr_out      - filtered VR signal
// Build option: define HWAG_PERIOD_EN to include the period counter,
// arming logic, PERIOD registers and PERIOD_VALID status bit.
module hwag
  import hwag_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ssram_we,
  input  logic              ssram_re,
  input  logic [ADDR_W-1:0] ssram_addr,
  inout  wire  [DATA_W-1:0] ssram_data,
  input  logic              vr_in,
  output logic              vr_out
);

  data_t       regs_q [REG_NUM];
  data_t       hwacr0_q;
  data_t       rdata;
  logic        en;
  logic        in_array;
  logic [31:0] period_w;
  logic        pvalid_w;

  assign en       = hwacr0_q[HWACR0_EN_BIT];
  assign in_array = (ssram_addr[ADDR_W-1:REG_IDX_W] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      hwacr0_q <= '0;
    end else if (ssram_we) begin
      if (in_array) begin
        regs_q[ssram_addr[REG_IDX_W-1:0]] <= ssram_data;
      end else if (ssram_addr == HWACR0_ADDR) begin
        hwacr0_q <= ssram_data;
      end
    end
  end

  hwag_vr_filter u_vr_filter (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .filter (regs_q[FILTER_ADDR[REG_IDX_W-1:0]]),
    .vr_in  (vr_in),
    .vr_out (vr_out)
  );

`ifdef HWAG_PERIOD_EN
  logic [31:0] per_cnt_q, period_q;
  logic        armed_q, pvalid_q, vr_prev_q;
  logic        vr_rise;

  assign vr_rise = vr_out && !vr_prev_q;

  // The first rising edge after enabling only arms the capture so that a
  // partial tooth is never reported as a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q <= '0;
      period_q  <= '0;
      armed_q   <= 1'b0;
      pvalid_q  <= 1'b0;
      vr_prev_q <= 1'b0;
    end else begin
      vr_prev_q <= vr_out;
      if (!en) begin
        per_cnt_q <= '0;
        armed_q   <= 1'b0;
        pvalid_q  <= 1'b0;
      end else if (vr_rise) begin
        per_cnt_q <= 32'd1;
        armed_q   <= 1'b1;
        if (armed_q) begin
          period_q <= per_cnt_q;
          pvalid_q <= 1'b1;
        end
      end else if (per_cnt_q != '1) begin
        per_cnt_q <= per_cnt_q + 32'd1;
      end
    end
  end

  assign period_w = period_q;
  assign pvalid_w = pvalid_q;
`else
  assign period_w = '0;
  assign pvalid_w = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (in_array) begin
      rdata = regs_q[ssram_addr[REG_IDX_W-1:0]];
    end else begin
      case (ssram_addr)
        HWACR0_ADDR: rdata = hwacr0_q;
        HWASR0_ADDR: begin
          rdata[HWASR0_VR_BIT] = vr_out;
          rdata[HWASR0_PV_BIT] = pvalid_w;
        end
        PERIOD_LO_ADDR: rdata = period_w[15:0];
        PERIOD_HI_ADDR: rdata = period_w[31:16];
        default: rdata = '0;
      endcase
    end
  end

  // A simultaneous write wins: the bus stays released so the host can drive it.
  assign ssram_data = (ssram_re && !ssram_we) ? rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_hwag.sv
// tb_hwag: directed test of hwag with a cycle-level behavioural model of
// the register map, filter and period capture.
module tb_hwag;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0, re = 1'b0;
  logic [7:0]  addr = 8'd0;
  logic [15:0] drv = 16'd0;
  logic        drv_en = 1'b0;
  logic        vr_in = 1'b0;
  wire  [15:0] ssram_data;
  logic        vr_out;
  logic        chk_on = 1'b0;

  int checks = 0;
  int errors = 0;

`ifdef HWAG_PERIOD_EN
  localparam int EXP_PERIOD = 20;
  localparam logic [15:0] EXP_STAT_VALID = 16'h0002;
`else
  localparam int EXP_PERIOD = 0;
  localparam logic [15:0] EXP_STAT_VALID = 16'h0000;
`endif

  assign ssram_data = drv_en ? drv : 16'hzzzz;

  hwag dut (
    .clk        (clk),
    .rst        (rst),
    .ssram_we   (we),
    .ssram_re   (re),
    .ssram_addr (addr),
    .ssram_data (ssram_data),
    .vr_in      (vr_in),
    .vr_out     (vr_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0] m_regs [64];
  logic [15:0] m_ctrl;
  logic        m_out, m_d1, m_d2, m_vs, m_pend, m_armed, m_valid;
  int          m_run, m_cyc, m_last;
  logic [31:0] m_period;

  // vr_in reaches the filter decision two edges after it is sampled; the
  // output flips once the delayed input has disagreed for FILTER+1 edges.
  // A rise is seen by the period logic on the edge after vr_out goes high,
  // and the period is the number of edges between consecutive rises.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) m_regs[i] = 16'd0;
      m_ctrl = 16'd0; m_out = 1'b0; m_d1 = 1'b0; m_d2 = 1'b0;
      m_pend = 1'b0; m_armed = 1'b0; m_valid = 1'b0;
      m_run = 0; m_cyc = 0; m_last = 0; m_period = 32'd0;
    end else begin
      m_cyc++;
      m_vs = m_d2; m_d2 = m_d1; m_d1 = vr_in;
      if (!m_ctrl[0]) begin
        m_out = 1'b0; m_run = 0; m_pend = 1'b0; m_armed = 1'b0; m_valid = 1'b0;
      end else begin
        if (m_pend) begin
          if (m_armed) begin
            m_period = (m_cyc - m_last);
            m_valid  = 1'b1;
          end
          m_armed = 1'b1;
          m_last  = m_cyc;
        end
        m_pend = 1'b0;
        if (m_vs != m_out) begin
          m_run++;
          if (m_run == m_regs[0] + 1) begin
            m_out = m_vs;
            m_run = 0;
            if (m_vs) m_pend = 1'b1;
          end
        end else begin
          m_run = 0;
        end
      end
      if (we) begin
        if (addr < 8'd64) m_regs[addr[5:0]] = drv;
        else if (addr == 8'd64) m_ctrl = drv;
      end
    end
  end

  function automatic logic [15:0] exp_rd(input logic [7:0] a);
    if (a < 8'd64) return m_regs[a[5:0]];
    if (a == 8'd64) return m_ctrl;
`ifdef HWAG_PERIOD_EN
    if (a == 8'd65) return {14'd0, m_valid, m_out};
    if (a == 8'd66) return m_period[15:0];
    if (a == 8'd67) return m_period[31:16];
`else
    if (a == 8'd65) return {15'd0, m_out};
`endif
    return 16'd0;
  endfunction

  // Per-cycle comparison of the filtered output against the model.
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      checks++;
      if (vr_out !== m_out) begin
        errors++;
        $display("FAIL vr_out_model cyc %0d: got %b expected %b", m_cyc, vr_out, m_out);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    we = 1'b1; addr = a; drv = d; drv_en = 1'b1;
    tick(1);
    we = 1'b0; drv_en = 1'b0;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [15:0] exp, input string nm);
    re = 1'b1; addr = a;
    #1;
    checks++;
    if (ssram_data !== exp) begin
      errors++;
      $display("FAIL %s addr %0d: got %h expected %h", nm, a, ssram_data, exp);
    end
    re = 1'b0;
    tick(1);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    chk_on = 1'b1;

    // reset readback
    for (int a = 0; a < 68; a++) rd_chk(8'(a), 16'h0000, "reset_rd");

    // register bank write/read, RO and unmapped writes ignored
    for (int a = 0; a < 64; a++) wr(8'(a), 16'(a + 1));
    wr(8'd64, 16'h0001);
    wr(8'd65, 16'hFFFF);
    wr(8'd200, 16'hBEEF);
    for (int a = 0; a < 64; a++) rd_chk(8'(a), 16'(a + 1), "rw_array");
    rd_chk(8'd64, 16'h0001, "hwacr0");
    rd_chk(8'd65, 16'h0000, "hwasr0_ro");
    rd_chk(8'd65, exp_rd(8'd65), "hwasr0_model");
    rd_chk(8'd100, 16'h0000, "unmapped_100");
    rd_chk(8'd200, 16'h0000, "unmapped_200");

    // simultaneous we/re: write happens, DUT leaves the bus alone
    we = 1'b1; re = 1'b1; addr = 8'd10; drv = 16'h1234; drv_en = 1'b1;
    #1;
    checks++;
    if (ssram_data !== 16'h1234) begin
      errors++;
      $display("FAIL we_re_bus: got %h expected %h", ssram_data, 16'h1234);
    end
    tick(1);
    we = 1'b0; re = 1'b0; drv_en = 1'b0;
    rd_chk(8'd10, 16'h1234, "we_re_write");

    // idle bus: only the bench drives it
    addr = 8'd5; drv = 16'h5A5A; drv_en = 1'b1;
    #1;
    checks++;
    if (ssram_data !== 16'h5A5A) begin
      errors++;
      $display("FAIL hiz_idle: got %h expected %h", ssram_data, 16'h5A5A);
    end
    drv_en = 1'b0;
    tick(1);

    // filter bypass: latency 3 edges, then a 20-clock square wave
    wr(8'd0, 16'h0000);
    tick(3);
    vr_in = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (vr_out) break;
    end
    #1;
    chk("bypass_latency", n, 3);
    tick(7);
    vr_in = 1'b0; tick(10);
    for (int i = 0; i < 3; i++) begin
      vr_in = 1'b1; tick(10);
      vr_in = 1'b0; tick(10);
    end
    rd_chk(8'd66, 16'(EXP_PERIOD), "period_lo");
    rd_chk(8'd67, 16'h0000, "period_hi");
    rd_chk(8'd66, exp_rd(8'd66), "period_lo_model");
    rd_chk(8'd65, EXP_STAT_VALID, "status_valid");

    // glitch rejection with FILTER=4
    wr(8'd0, 16'd4);
    tick(8);
    vr_in = 1'b1; tick(4); vr_in = 1'b0;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (vr_out) seen = 1; end
    #1;
    chk("glitch_4cyc_rejected", seen, 0);
    vr_in = 1'b1; tick(6); vr_in = 1'b0;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (vr_out) seen = 1; end
    #1;
    chk("glitch_6cyc_passed", seen, 1);

    // disable mid-stream with FILTER=0
    wr(8'd0, 16'h0000);
    tick(5);
    for (int i = 0; i < 2; i++) begin
      vr_in = 1'b1; tick(10);
      vr_in = 1'b0; tick(10);
    end
    vr_in = 1'b1; tick(6);
    chk("pre_disable_vr_out", int'(vr_out), 1);
    rd_chk(8'd66, 16'(EXP_PERIOD), "period_before_disable");
    wr(8'd64, 16'h0000);
    @(posedge clk); #1;
    chk("disable_vr_out", int'(vr_out), 0);
    #1;
    rd_chk(8'd65, 16'h0000, "disable_status");
    rd_chk(8'd66, 16'(EXP_PERIOD), "period_hold");

    // asynchronous reset mid-operation
    wr(8'd64, 16'h0001);
    wr(8'd3, 16'h0BAD);
    tick(6);
    rd_chk(8'd3, 16'h0BAD, "pre_reset_reg");
    rst = 1'b1;
    #1;
    chk("reset_vr_out", int'(vr_out), 0);
    rd_chk(8'd3, 16'h0000, "reset_async_reg");
    rst = 1'b0;
    rd_chk(8'd64, 16'h0000, "reset_hwacr0");
    rd_chk(8'd66, 16'h0000, "reset_period");
    tick(8);
    chk("after_reset_vr_out", int'(vr_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
